// File: rtl/track_sequencer_pkg.sv
// Shared definitions for the multi-track note sequencer.
// Holds the play-mode codes, the FSM state type and default bus widths.
// Pure declarations; no logic, no latency, no flow control.
package track_sequencer_pkg;

  localparam int NUM_TRACKS_DEF = 4;
  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 16;

  localparam logic [1:0] MODE_SEQ    = 2'd0;
  localparam logic [1:0] MODE_RAND   = 2'd1;
  localparam logic [1:0] MODE_CHOICE = 2'd2;
  localparam logic [1:0] MODE_ONCE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_PAUSE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/track_sequencer_if.sv
// Control, ROM and audio-output bundle of the track sequencer.
// master = controller/ROM/audio side, slave = sequencer core.
// No flow control: clk_48hz is a one-cycle strobe, outputs are pulses.
interface track_sequencer_if #(
  parameter int TRK_W  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              clk_48hz;
  logic              pause;
  logic [1:0]        mode;
  logic [2:0]        choice;
  logic [2:0]        rand_in;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic [TRK_W-1:0]  track_num;
  logic              track_done;

  modport master (
    output clk_48hz, pause, mode, choice, rand_in, rom_data,
    input  rom_addr, sample_out, sample_valid, track_num, track_done
  );

  modport slave (
    input  clk_48hz, pause, mode, choice, rand_in, rom_data,
    output rom_addr, sample_out, sample_valid, track_num, track_done
  );
endinterface

// File: rtl/track_sequencer_next_track_sel.sv
// Picks the track that follows the current one when a track ends.
// Ports: mode, track, rand_in in; next_track, done_flag (play-once stop) out.
// Purely combinational, zero latency, no flow control.
module track_sequencer_next_track_sel
  import track_sequencer_pkg::*;
#(
  parameter int NUM_TRACKS = NUM_TRACKS_DEF,
  parameter int TRK_W      = $clog2(NUM_TRACKS)
) (
  input  logic [1:0]       mode,
  input  logic [TRK_W-1:0] track,
  input  logic [2:0]       rand_in,
  output logic [TRK_W-1:0] next_track,
  output logic             done_flag
);

  logic [TRK_W-1:0] r;

  always_comb begin
    next_track = track;
    done_flag  = 1'b0;
    r          = TRK_W'(int'(rand_in) % NUM_TRACKS);
    case (mode)
      MODE_SEQ: begin
        next_track = (int'(track) == NUM_TRACKS - 1) ? '0 : track + 1'b1;
      end
      MODE_RAND: begin
        // Bump a repeat draw by one so the same track never plays twice in a row.
        if (r == track) begin
          next_track = (int'(r) == NUM_TRACKS - 1) ? '0 : r + 1'b1;
        end else begin
          next_track = r;
        end
      end
      MODE_CHOICE: next_track = track;
      default:     done_flag  = 1'b1;
    endcase
  end

endmodule

// File: rtl/track_sequencer.sv
// Multi-track note sequencer: walks a shared ROM track by track, one note per clk_48hz tick.
// Ports: clk, rst (sync, active-high), bus (slave side of track_sequencer_if).
// Latency: sample_valid two clocks after the accepting tick; pause drains the note pipeline.
module track_sequencer
  import track_sequencer_pkg::*;
#(
  parameter int                            NUM_TRACKS = NUM_TRACKS_DEF,
  parameter int                            TRK_W      = $clog2(NUM_TRACKS),
  parameter int                            ADDR_W     = ADDR_W_DEF,
  parameter int                            DATA_W     = DATA_W_DEF,
  parameter logic [NUM_TRACKS*ADDR_W-1:0]  TRACK_BASE = {8'd88, 8'd80, 8'd70, 8'd0},
  parameter logic [NUM_TRACKS*ADDR_W-1:0]  TRACK_LEN  = {8'd12, 8'd8, 8'd10, 8'd70}
) (
  input  logic        clk,
  input  logic        rst,
  track_sequencer_if.slave bus
);

  state_t              state_q, state_d;
  logic [TRK_W-1:0]    track_q;
  logic [ADDR_W-1:0]   offset_q;
  logic                done_q;
  logic                s1_q, s2_q, valid_q;
  logic [DATA_W-1:0]   sample_q;

  logic [ADDR_W-1:0]   base_tab [NUM_TRACKS];
  logic [ADDR_W-1:0]   last_tab [NUM_TRACKS];

  logic                start, step, jump, end_trk, launch, at_end;
  logic                choice_ok, done_flag;
  logic [TRK_W-1:0]    choice_trk, nxt_track;

  // Unpack per-track tables; a zero length behaves as a one-note track.
  for (genvar i = 0; i < NUM_TRACKS; i++) begin : g_tab
    localparam logic [ADDR_W-1:0] LEN = TRACK_LEN[i*ADDR_W +: ADDR_W];
    assign base_tab[i] = TRACK_BASE[i*ADDR_W +: ADDR_W];
    assign last_tab[i] = (LEN == '0) ? '0 : LEN - 1'b1;
  end

  assign choice_ok  = int'(bus.choice) < NUM_TRACKS;
  assign choice_trk = TRK_W'(bus.choice);
  assign at_end     = (offset_q == last_tab[track_q]);

  track_sequencer_next_track_sel #(
    .NUM_TRACKS (NUM_TRACKS),
    .TRK_W      (TRK_W)
  ) u_next_track_sel (
    .mode       (bus.mode),
    .track      (track_q),
    .rand_in    (bus.rand_in),
    .next_track (nxt_track),
    .done_flag  (done_flag)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_PLAY;
      ST_PLAY: begin
        if (bus.pause)                state_d = ST_PAUSE;
        else if (end_trk && done_flag) state_d = ST_DONE;
      end
      ST_PAUSE: if (!bus.pause) state_d = ST_PLAY;
      default:  if (bus.mode != MODE_ONCE) state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: which kind of tick is accepted this cycle.
  always_comb begin
    start = 1'b0;
    step  = 1'b0;
    case (state_q)
      ST_IDLE: start = bus.clk_48hz & ~bus.pause;
      ST_PLAY: step  = bus.clk_48hz & ~bus.pause;
      default: ;
    endcase
  end

  // A mode-2 jump pre-empts the end-of-track rule and never counts as a track end.
  assign jump    = step & (bus.mode == MODE_CHOICE) & choice_ok & (choice_trk != track_q);
  assign end_trk = step & ~jump & at_end;
  assign launch  = start | (step & ~(end_trk & done_flag));

  // Track / offset position.
  always_ff @(posedge clk) begin
    if (rst) begin
      track_q  <= '0;
      offset_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        track_q  <= (bus.mode == MODE_CHOICE && choice_ok) ? choice_trk : '0;
        offset_q <= '0;
      end else if (jump) begin
        track_q  <= choice_trk;
        offset_q <= '0;
      end else if (end_trk) begin
        done_q   <= 1'b1;
        offset_q <= '0;
        track_q  <= nxt_track;
      end else if (step) begin
        offset_q <= offset_q + 1'b1;
      end
    end
  end

  // Note pipeline: s1 = address just updated, s2 = ROM word captured, then output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      valid_q  <= 1'b0;
      sample_q <= '0;
    end else if (bus.pause || state_q == ST_DONE) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      valid_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      s1_q    <= launch;
      s2_q    <= s1_q;
      valid_q <= s2_q;
      if (s2_q) sample_q <= bus.rom_data;
    end
  end

  assign bus.rom_addr     = base_tab[track_q] + offset_q;
  assign bus.track_num    = track_q;
  assign bus.track_done   = done_q;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_track_sequencer.sv
// Self-checking bench for track_sequencer: directed scenarios then random stimulus.
// A behavioural model (track/offset integers, queue of pending notes) predicts every output.
// Outputs compared each falling edge; inputs driven on falling edges.
module tb_track_sequencer;

  localparam int NT = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 0;

  int          t_base [NT] = '{0, 8, 252, 40};
  int          t_len  [NT] = '{2, 3, 6, 0};
  logic [15:0] rom    [256];

  track_sequencer_if #(.TRK_W(2), .ADDR_W(8), .DATA_W(16)) bus ();

  track_sequencer #(
    .NUM_TRACKS (NT),
    .TRK_W      (2),
    .ADDR_W     (8),
    .DATA_W     (16),
    .TRACK_BASE ({8'd40, 8'd252, 8'd8, 8'd0}),
    .TRACK_LEN  ({8'd0, 8'd6, 8'd3, 8'd2})
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle read latency.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_track, m_off;
  bit          m_run, m_paused, m_done, m_tdone, m_sval;
  logic [15:0] m_sout;
  int          pend_age [$];
  logic [15:0] pend_dat [$];

  function automatic int eff_len(input int t);
    return (t_len[t] == 0) ? 1 : t_len[t];
  endfunction

  function automatic int addr_of(input int t, input int o);
    return (t_base[t] + o) % 256;
  endfunction

  always @(posedge clk) begin
    bit launch;
    bit kill;
    int r;
    launch = 0;
    if (rst) begin
      m_run = 0; m_paused = 0; m_done = 0; m_track = 0; m_off = 0;
      m_tdone = 0; m_sval = 0; m_sout = '0;
      pend_age.delete(); pend_dat.delete();
    end else begin
      m_tdone = 0;
      m_sval  = 0;
      kill = bus.pause || m_done;
      if (kill) begin
        pend_age.delete(); pend_dat.delete();
        m_sout = '0;
      end else begin
        foreach (pend_age[i]) pend_age[i]++;
        if (pend_age.size() > 0 && pend_age[0] == 2) begin
          m_sval = 1;
          m_sout = pend_dat[0];
          void'(pend_age.pop_front());
          void'(pend_dat.pop_front());
        end
      end

      if (m_done) begin
        if (bus.mode != 2'd3) m_done = 0;
      end else if (!m_run) begin
        if (bus.clk_48hz && !bus.pause) begin
          m_run   = 1;
          m_track = (bus.mode == 2'd2 && int'(bus.choice) < NT) ? int'(bus.choice) : 0;
          m_off   = 0;
          launch  = 1;
        end
      end else if (m_paused) begin
        if (!bus.pause) m_paused = 0;
      end else if (bus.pause) begin
        m_paused = 1;
      end else if (bus.clk_48hz) begin
        if (bus.mode == 2'd2 && int'(bus.choice) < NT && int'(bus.choice) != m_track) begin
          m_track = int'(bus.choice);
          m_off   = 0;
          launch  = 1;
        end else if (m_off >= eff_len(m_track) - 1) begin
          m_tdone = 1;
          m_off   = 0;
          case (bus.mode)
            2'd0: begin m_track = (m_track + 1) % NT; launch = 1; end
            2'd1: begin
              r = int'(bus.rand_in) % NT;
              if (r == m_track) r = (r + 1) % NT;
              m_track = r;
              launch  = 1;
            end
            2'd2: launch = 1;
            default: begin m_done = 1; m_run = 0; end
          endcase
        end else begin
          m_off++;
          launch = 1;
        end
      end
      if (launch) begin
        pend_age.push_back(0);
        pend_dat.push_back(rom[addr_of(m_track, m_off)]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("track_num",    bus.track_num,    m_track);
      check("rom_addr",     bus.rom_addr,     addr_of(m_track, m_off));
      check("sample_valid", bus.sample_valid, m_sval);
      check("track_done",   bus.track_done,   m_tdone);
      check("sample_out",   bus.sample_out,   m_sout);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit tk);
    bus.clk_48hz = tk;
    @(negedge clk);
    bus.clk_48hz = 1'b0;
  endtask

  task automatic tick_gap();
    cyc(1'b1);
    repeat (3) cyc(1'b0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 16'($urandom) | 16'h8000;
    rst = 1'b1;
    bus.clk_48hz = 1'b0;
    bus.pause    = 1'b0;
    bus.mode     = 2'd0;
    bus.choice   = 3'd0;
    bus.rand_in  = 3'd0;
    @(negedge clk);
    chk_en = 1;
    check("rst_track", bus.track_num, 0);
    check("rst_valid", bus.sample_valid, 0);
    check("rst_sample", bus.sample_out, 0);
    cyc(1'b0);
    rst = 1'b0;

    // In-order play through tracks 0..2, landing at the start of track 3.
    repeat (12) tick_gap();
    check("seq_track", bus.track_num, 3);

    // Last track wraps back to track 0.
    cyc(1'b1);
    check("wrap_track", bus.track_num, 0);
    check("wrap_done", bus.track_done, 1);
    check("wrap_addr", bus.rom_addr, 0);
    repeat (3) cyc(1'b0);

    // Random mode.
    bus.mode = 2'd1;
    bus.rand_in = 3'd2;
    tick_gap();
    cyc(1'b1);
    check("rand_track", bus.track_num, 2);
    repeat (3) cyc(1'b0);
    repeat (5) tick_gap();
    bus.rand_in = 3'd6;
    cyc(1'b1);
    check("rand_norepeat", bus.track_num, 3);
    repeat (3) cyc(1'b0);

    // Chosen-loop jumps.
    bus.mode = 2'd2;
    bus.choice = 3'd0;
    tick_gap();
    bus.choice = 3'd3;
    cyc(1'b1);
    check("jump_addr", bus.rom_addr, 40);
    check("jump_nodone", bus.track_done, 0);
    repeat (3) cyc(1'b0);
    bus.choice = 3'd5;
    cyc(1'b1);
    check("bad_choice", bus.track_num, 3);
    repeat (3) cyc(1'b0);

    // Pause at offset 4 of track 2.
    bus.choice = 3'd2;
    tick_gap();
    bus.mode = 2'd0;
    repeat (4) tick_gap();
    bus.pause = 1'b1;
    repeat (10) begin cyc(1'b1); cyc(1'b0); end
    check("pause_sample", bus.sample_out, 0);
    check("pause_addr", bus.rom_addr, 0);
    check("pause_valid", bus.sample_valid, 0);
    bus.pause = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    check("resume_addr", bus.rom_addr, 1);
    cyc(1'b0);
    check("resume_early", bus.sample_valid, 0);
    cyc(1'b0);
    check("resume_valid", bus.sample_valid, 1);
    check("resume_sample", bus.sample_out, {16'd0, rom[1]});

    // Play-once end, exit to idle, then reset mid-play.
    bus.mode = 2'd3;
    cyc(1'b1);
    check("once_done", bus.track_done, 1);
    check("once_track", bus.track_num, 2);
    repeat (2) cyc(1'b0);
    check("once_mute", bus.sample_out, 0);
    bus.mode = 2'd0;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    check("mid_rst_track", bus.track_num, 0);
    check("mid_rst_valid", bus.sample_valid, 0);
    check("mid_rst_sample", bus.sample_out, 0);

    // Random phase.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.pause = ~bus.pause;
      if ($urandom_range(0, 19) == 0) bus.choice = 3'($urandom_range(0, 7));
      bus.rand_in = 3'($urandom_range(0, 7));
      cyc($urandom_range(0, 2) == 0);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
